// File: rtl/walu_pkg.sv
// Shared types for the walu datapath: data word, ALU opcode, and arbiter state.
package walu_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SLT = 3'd7
  } type_op;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int WALU_ARB_NREQ = 4;

endpackage

// File: rtl/walu_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or above ptr,
// wrapping past NREQ-1 back to 0.
module rr_picker #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  int          cand;
  logic [IW-1:0] cand_idx;

  // Scan from farthest to nearest so the candidate closest to ptr overwrites the rest.
  always_comb begin
    grant    = '0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IW'(cand);
      if (req[cand_idx]) begin
        grant           = '0;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/walu_arbiter.sv
// Round-robin sharing of one combinational ALU among NREQ requesters.
// Define WALU_ARB_STATS_EN to add the saturating op_count completion counter.
module walu_arbiter
  import walu_pkg::*;
#(
  parameter  int NREQ = WALU_ARB_NREQ,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  data_t           req_a [NREQ],
  input  data_t           req_b [NREQ],
  input  type_op          req_op [NREQ],
  output data_t           alu_a,
  output data_t           alu_b,
  output type_op          alu_op,
  input  data_t           alu_r,
  output logic [NREQ-1:0] rsp_valid,
  output data_t           rsp_r,
  input  logic [NREQ-1:0] rsp_ready
`ifdef WALU_ARB_STATS_EN
  ,
  output logic [31:0]     op_count
`endif
);

  arb_state_t      state, next_state;
  logic [IW-1:0]   ptr, id, win_idx;
  logic [NREQ-1:0] win_grant;
  data_t           res;
  logic            grant_fire;
  logic            done;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx)
  );

  always_comb begin
    next_state = state;
    req_ready  = '0;
    rsp_valid  = '0;
    grant_fire = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready  = win_grant;
          grant_fire = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: next_state = RESP;
      RESP: begin
        rsp_valid[id] = 1'b1;
        if (rsp_ready[id]) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand registers only load on a grant, keeping the ALU input steady through EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      id     <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= type_op'(3'd0);
      res    <= '0;
    end else begin
      state <= next_state;
      if (grant_fire) begin
        alu_a  <= req_a[win_idx];
        alu_b  <= req_b[win_idx];
        alu_op <= req_op[win_idx];
        id     <= win_idx;
      end
      if (state == EXEC) res <= alu_r;
      if (done) ptr <= (id == IW'(NREQ - 1)) ? '0 : id + 1'b1;
    end
  end

  assign rsp_r = res;

`ifdef WALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (done && (op_count != 32'hFFFF_FFFF)) begin
      op_count <= op_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_walu_arbiter.sv
// Directed self-checking bench for walu_arbiter with a behavioural ALU model.
// Counter checks are compiled in when WALU_ARB_STATS_EN is defined.
module tb_walu_arbiter;
  import walu_pkg::*;

  localparam int NREQ = 4;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  data_t           req_a [NREQ];
  data_t           req_b [NREQ];
  type_op          req_op [NREQ];
  data_t           alu_a, alu_b, alu_r, rsp_r;
  type_op          alu_op;
  logic [NREQ-1:0] rsp_valid;
  logic [NREQ-1:0] rsp_ready;
`ifdef WALU_ARB_STATS_EN
  logic [31:0]     op_count;
`endif

  int total = 0;
  int bad   = 0;

  walu_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_r     (alu_r),
    .rsp_valid (rsp_valid),
    .rsp_r     (rsp_r),
    .rsp_ready (rsp_ready)
`ifdef WALU_ARB_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_r = '0;
    case (alu_op)
      OP_ADD:  alu_r = alu_a + alu_b;
      OP_SUB:  alu_r = alu_a - alu_b;
      OP_AND:  alu_r = alu_a & alu_b;
      OP_OR:   alu_r = alu_a | alu_b;
      OP_XOR:  alu_r = alu_a ^ alu_b;
      default: alu_r = '0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] ready);
    req_valid = valid;
    rsp_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Requester i: a=10*(i+1), b=i+1; results 11, 18, 29, 44.
  task automatic setContentionOperands();
    req_a[0] = 32'd10; req_b[0] = 32'd1; req_op[0] = OP_ADD;
    req_a[1] = 32'd20; req_b[1] = 32'd2; req_op[1] = OP_SUB;
    req_a[2] = 32'd30; req_b[2] = 32'd3; req_op[2] = OP_XOR;
    req_a[3] = 32'd40; req_b[3] = 32'd4; req_op[3] = OP_OR;
  endtask

  initial begin
    int          exp_order [5];
    logic [31:0] exp_res   [4];
    exp_order = '{0, 1, 2, 3, 0};
    exp_res   = '{32'd11, 32'd18, 32'd29, 32'd44};

    rst = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = '0; req_b[i] = '0; req_op[i] = OP_ADD;
    end
    step();
    step();
    rst = 1'b0;
    checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_rsp_r", rsp_r, 32'h0);
    checkOutput("reset_alu_a", alu_a, 32'h0);
    checkOutput("reset_alu_b", alu_b, 32'h0);
    checkOutput("reset_alu_op", 32'(alu_op), 32'h0);

    $display("[TB] single request");
    req_a[0] = 32'd5; req_b[0] = 32'd3; req_op[0] = OP_ADD;
    applyStimulus(4'b0001, 4'b0001);
    #1;
    checkOutput("single_grant", 32'(req_ready), 32'h1);
    step();
    applyStimulus(4'b0000, 4'b0001);
    #1;
    checkOutput("single_alu_a", alu_a, 32'd5);
    checkOutput("single_alu_b", alu_b, 32'd3);
    checkOutput("single_alu_op", 32'(alu_op), 32'(OP_ADD));
    checkOutput("exec_no_ready", 32'(req_ready), 32'h0);
    checkOutput("exec_no_rsp", 32'(rsp_valid), 32'h0);
    step();
    checkOutput("single_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("single_rsp_r", rsp_r, 32'd8);
    step();
    checkOutput("single_rsp_done", 32'(rsp_valid), 32'h0);

    $display("[TB] contention");
    rst = 1'b1;
    step();
    rst = 1'b0;
    setContentionOperands();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 4'b1111);
      #1;
      checkOutput($sformatf("cont_grant_%0d", i), 32'(req_ready), 32'(1) << exp_order[i]);
      step();
      checkOutput($sformatf("cont_exec_%0d", i), 32'(rsp_valid), 32'h0);
      step();
      checkOutput($sformatf("cont_rsp_valid_%0d", i), 32'(rsp_valid), 32'(1) << exp_order[i]);
      checkOutput($sformatf("cont_rsp_r_%0d", i), rsp_r, exp_res[exp_order[i]]);
      step();
    end

    $display("[TB] wrap-around");
    applyStimulus(4'b1000, 4'b1111);
    #1;
    checkOutput("wrap_grant3", 32'(req_ready), 32'h8);
    step(); step(); step();
    applyStimulus(4'b1001, 4'b1111);
    #1;
    checkOutput("wrap_grant0", 32'(req_ready), 32'h1);
    step(); step(); step();
    #1;
    checkOutput("wrap_grant3_again", 32'(req_ready), 32'h8);
    step(); step(); step();

    $display("[TB] response backpressure");
    applyStimulus(4'b0100, 4'b0000);
    #1;
    checkOutput("bp_grant2", 32'(req_ready), 32'h4);
    step();
    applyStimulus(4'b0000, 4'b0000);
    step();
    applyStimulus(4'b0010, 4'b1011);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("bp_rsp_valid_%0d", i), 32'(rsp_valid), 32'h4);
      checkOutput($sformatf("bp_rsp_r_%0d", i), rsp_r, 32'd29);
      checkOutput($sformatf("bp_req_ready_%0d", i), 32'(req_ready), 32'h0);
      checkOutput($sformatf("bp_alu_a_%0d", i), alu_a, 32'd30);
      step();
    end
    applyStimulus(4'b0010, 4'b0100);
    step();
    checkOutput("bp_after_grant1", 32'(req_ready), 32'h2);
    applyStimulus(4'b0010, 4'b0010);
    step();
    checkOutput("bp_after_alu_a", alu_a, 32'd20);
    applyStimulus(4'b0000, 4'b0010);
    step();
    checkOutput("bp_after_rsp_r", rsp_r, 32'd18);
    step();
`ifdef WALU_ARB_STATS_EN
    checkOutput("stats_count_11", op_count, 32'd11);
`endif

    $display("[TB] reset during response");
    applyStimulus(4'b0100, 4'b0000);
    #1;
    checkOutput("rr_grant2", 32'(req_ready), 32'h4);
    step();
    applyStimulus(4'b0000, 4'b0000);
    step();
    checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'h4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rr_rsp_valid_cleared", 32'(rsp_valid), 32'h0);
    checkOutput("rr_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rr_rsp_r", rsp_r, 32'h0);
    checkOutput("rr_alu_a", alu_a, 32'h0);
    checkOutput("rr_alu_b", alu_b, 32'h0);
    checkOutput("rr_alu_op", 32'(alu_op), 32'h0);
`ifdef WALU_ARB_STATS_EN
    checkOutput("stats_cleared", op_count, 32'd0);
`endif
    step();
    checkOutput("rr_no_late_rsp", 32'(rsp_valid), 32'h0);
    applyStimulus(4'b1111, 4'b1111);
    #1;
    checkOutput("rr_ptr_zero", 32'(req_ready), 32'h1);
    step(); step(); step();
`ifdef WALU_ARB_STATS_EN
    checkOutput("stats_count_1", op_count, 32'd1);
    applyStimulus(4'b0000, 4'b1111);
    force dut.op_count = 32'hFFFF_FFFF;
    #1;
    release dut.op_count;
    applyStimulus(4'b0001, 4'b1111);
    step();
    applyStimulus(4'b0000, 4'b1111);
    step(); step();
    checkOutput("stats_saturate", op_count, 32'hFFFF_FFFF);
`endif

    applyStimulus(4'b0000, 4'b0000);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/walu_arbiter.md
# walu_arbiter

Round-robin controller that shares the single combinational ALU (`a`, `b`, `op` in; `r` out) among `NREQ` requesters. Each requester presents operands and an opcode with a valid/ready handshake. The arbiter registers the winning request into the ALU operand registers, captures the result one cycle later, and returns it on a per-requester response handshake. It sits between the requester ports and the ALU instance, and owns all ALU input registers.

## Interface
- `NREQ`, 4: number of requesters, ≥2; non-power-of-two values are allowed.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NREQ`: request pending, one bit per requester. Must not depend on `req_ready`.
- `req_ready` out `NREQ`: one-hot grant; the request is accepted in the cycle where `req_valid[i] && req_ready[i]`.
- `req_a`, `req_b` in `NREQ` x `data_t`: operands per requester.
- `req_op` in `NREQ` x `type_op`: opcode per requester.
- `alu_a`, `alu_b` out `data_t`: registered ALU operands.
- `alu_op` out `type_op`: registered ALU opcode.
- `alu_r` in `data_t`: combinational ALU result.
- `rsp_valid` out `NREQ`: one-hot response valid.
- `rsp_r` out `data_t`: result for the requester flagged in `rsp_valid`.
- `rsp_ready` in `NREQ`: requester accepts the response.
- `op_count` out 32 (only with `WALU_ARB_STATS_EN`): count of completed transactions.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Any `req_valid` set: the picker selects a winner `w`; `req_ready[w]=1` combinationally in this cycle.
  - At the clock edge: `alu_a/alu_b/alu_op <= req_*[w]`, `id <= w`, go to EXEC.
  - No request: stay in IDLE, `req_ready=0`.
- EXEC: `res <= alu_r`; go to RESP. `req_ready=0`.
- RESP:
  - `rsp_valid[id]=1`, `rsp_r=res`.
  - On `rsp_ready[id]`: go to IDLE, set `ptr <= (id+1) mod NREQ`.
  - `rsp_ready` on other bits is ignored.
  - Response held stable until accepted; no timeout.
- Round-robin: search starts at `ptr` and scans upward with wrap-around. The first set `req_valid` bit wins.
- Pointer behaviour:
  - `ptr` advances only on response completion.
  - A lone requester may win back-to-back.
  - A requester that drops `req_valid` before grant is simply skipped.
- `req_ready` is asserted only in IDLE, and at most one bit at a time.
- `alu_a/alu_b/alu_op` hold their last values outside of IDLE grants, so the ALU input is stable through EXEC.
- Arithmetic is entirely in the ALU; the arbiter does not modify data widths.

## Timing
- Reset values:
  - State IDLE, `ptr=0`, `id=0`.
  - `req_ready=0`, `rsp_valid=0`.
  - `rsp_r=0`, `alu_a=0`, `alu_b=0`.
  - `alu_op` = `type_op` encoding 0.
  - `op_count=0`.
- Latency:
  - Request accepted at edge t.
  - ALU result captured at t+1.
  - `rsp_valid` high in the cycle after t+1.
  - Response completes at the first edge where `rsp_ready[id]` is high.
- Maximum throughput: one transaction per 3 cycles, when `rsp_ready` is held high.
- New request during RESP: not granted until the cycle after the response completes (IDLE).
- Simultaneous requests in IDLE: exactly one grant; the losers keep `req_valid` asserted and are served in rotating order.
- Reset mid-operation (EXEC or RESP): the transaction is dropped and no response is issued. All registers return to reset values at that edge.

## Configuration
- `WALU_ARB_STATS_EN` defined:
  - Adds the `op_count` port.
  - Increments by 1 on each response completion.
  - Saturates at 2^32-1.
  - Cleared by `rst`.
- `WALU_ARB_STATS_EN` undefined: port and counter are absent; behaviour is otherwise identical.

## Structure
- `walu_pkg` additions:
  - `arb_state_t` (IDLE/EXEC/RESP).
  - `WALU_ARB_NREQ` default constant.
- `data_t` and `type_op` are reused from the existing packages; no new data types.
- One sub-module, `rr_picker`: combinational round-robin priority encoder. Inputs: request vector, `ptr`. Outputs: one-hot grant and winner index.

## Test plan
- Reset, then one request:
  - `req_valid=0001`, a=5, b=3, op=add → `req_ready=0001` in the same cycle.
  - `rsp_valid=0001`, `rsp_r=8` two cycles later.
- Contention: `req_valid=1111` held, `rsp_ready` always high → grant order 0,1,2,3,0; one response every 3 cycles.
- Wrap-around: after a grant to 3, `req_valid=1001` → requester 0 wins, then requester 3.
- Response backpressure: `rsp_ready=0` for 5 cycles → `rsp_valid`/`rsp_r` stable, `req_ready=0`, and `alu_a` does not change despite `req_valid=0010`.
- Reset in RESP with `rsp_valid=0100` → next cycle all outputs are at reset values, no response, `ptr=0`.
- With `WALU_ARB_STATS_EN`: 10 completed transactions → `op_count=10`. Counter forced to 2^32-1 plus one completion → stays at 2^32-1.
